// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} lsu_size_e;

    typedef enum {ST_IDLE, ST_BUSY, ST_RESP} lsu_state_e;

    // Size 2'b11 has no legal encoding and is folded into the misaligned path.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane selection plus sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign misalign_o = lsu_misaligned(size_i, off_i);

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (off_i)
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            2'd3:    byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (size_i)
            SZ_B: begin
                case (off_i)
                    2'd1:    be_o = 4'b0010;
                    2'd2:    be_o = 4'b0100;
                    2'd3:    be_o = 4'b1000;
                    default: be_o = 4'b0001;
                endcase
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/ack bus FSM with misalignment and timeout reporting.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_buserr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        req_ready_q, resp_valid_q, resp_misalign_q, resp_buserr_q;
    logic [31:0] resp_rdata_q;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic [1:0]  size_q, off_q;
    logic        uns_q;

    logic        idle;
    logic [1:0]  sel_size, sel_off;
    logic        sel_uns;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misalign;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
    assign idle     = (state_q == ST_IDLE);
    assign sel_size = idle ? req_size     : size_q;
    assign sel_off  = idle ? addr[1:0]    : off_q;
    assign sel_uns  = idle ? req_unsigned : uns_q;

    lsu_align u_align (
        .size_i     (sel_size),
        .off_i      (sel_off),
        .uns_i      (sel_uns),
        .wdata_i    (wdata),
        .rdata_i    (mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (idle && req_valid) begin
            size_q <= req_size;
            off_q  <= addr[1:0];
            uns_q  <= req_unsigned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_misalign_q <= 1'b0;
            resp_buserr_q   <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_be_q        <= 4'h0;
            mem_wdata_q     <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (al_misalign) begin
                            state_q         <= ST_RESP;
                            resp_valid_q    <= 1'b1;
                            resp_misalign_q <= 1'b1;
                        end else begin
                            state_q     <= ST_BUSY;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= al_be;
                            mem_wdata_q <= al_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (mem_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                        state_q       <= ST_RESP;
                        resp_valid_q  <= 1'b1;
                        resp_buserr_q <= !mem_ack;
                        resp_rdata_q  <= (mem_ack && !mem_we_q) ? al_rdata : 32'h0;
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        mem_addr_q    <= 32'h0;
                        mem_be_q      <= 4'h0;
                        mem_wdata_q   <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q         <= ST_IDLE;
                    req_ready_q     <= 1'b1;
                    resp_valid_q    <= 1'b0;
                    resp_rdata_q    <= 32'h0;
                    resp_misalign_q <= 1'b0;
                    resp_buserr_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_misalign = resp_misalign_q;
    assign resp_buserr   = resp_buserr_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected responses, a monitor pops and compares them.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_buserr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .resp_buserr   (resp_buserr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] rd, input logic mis, input logic berr);
        exp_t e;
        e.rdata = rd;
        e.mis   = mis;
        e.berr  = berr;
        sb.push_back(e);
    endtask

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_misalign", {31'h0, resp_misalign}, {31'h0, e.mis});
                    check("resp_buserr", {31'h0, resp_buserr}, {31'h0, e.berr});
                end
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        addr         = a;
        wdata        = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic access_ack1(input string name, input logic we, input logic [1:0] sz,
                               input logic uns, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic [3:0] exp_be,
                               input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        push(exp_rd, 1'b0, 1'b0);
        send(we, sz, uns, a, wd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        check({name, "_req"}, {31'h0, mem_req}, 32'h1);
        check({name, "_we"}, {31'h0, mem_we}, {31'h0, we});
        check({name, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({name, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
        check({name, "_wdata"}, mem_wdata, exp_wd);
        check({name, "_early"}, {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        check({name, "_lat"}, {31'h0, resp_valid}, 32'h1);
        wait_idle(name);
    endtask

    task automatic access_mis(input string name, input logic we, input logic [1:0] sz,
                              input logic [31:0] a);
        push(32'h0, 1'b1, 1'b0);
        send(we, sz, 1'b0, a, 32'hFFFF_FFFF);
        @(negedge clk);
        check({name, "_noreq"}, {31'h0, mem_req}, 32'h0);
        check({name, "_lat"}, {31'h0, resp_valid}, 32'h1);
        wait_idle(name);
    endtask

    initial begin
        int n;
        #12;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_be", {28'h0, mem_be}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        access_ack1("sb", 1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0,
                    4'b1000, 32'hABAB_ABAB, 32'h0);
        access_ack1("lh_s", 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234,
                    4'b1100, 32'h0, 32'hFFFF_8001);
        access_ack1("lh_u", 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_1234,
                    4'b1100, 32'h0, 32'h0000_8001);
        access_ack1("lb_s", 1'b0, 2'b00, 1'b0, 32'h7001, 32'h0, 32'h0000_8000,
                    4'b0010, 32'h0, 32'hFFFF_FF80);
        access_ack1("lbu", 1'b0, 2'b00, 1'b1, 32'h7002, 32'h0, 32'h00AB_0000,
                    4'b0100, 32'h0, 32'h0000_00AB);
        access_ack1("lh_lo", 1'b0, 2'b01, 1'b0, 32'h7000, 32'h0, 32'h1234_7FFF,
                    4'b0011, 32'h0, 32'h0000_7FFF);
        access_ack1("sh", 1'b1, 2'b01, 1'b0, 32'h7002, 32'hDEAD_1234, 32'h5555_5555,
                    4'b1100, 32'h1234_1234, 32'h0);
        access_ack1("sw", 1'b1, 2'b10, 1'b0, 32'h7004, 32'hCAFE_BABE, 32'h0,
                    4'b1111, 32'hCAFE_BABE, 32'h0);

        access_mis("lw_mis", 1'b0, 2'b10, 32'h3002);
        access_mis("sh_mis", 1'b1, 2'b01, 32'h3001);
        access_mis("sz11", 1'b0, 2'b11, 32'h3000);

        // Timeout: no ack ever, expect exactly 16 cycles of mem_req.
        push(32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 32'h4000, 32'h1111_2222);
        n = 0;
        do begin
            @(negedge clk);
            if (mem_req === 1'b1) n++;
        end while (mem_req === 1'b1 && n < 100);
        check("to_req_cycles", n, 32'd16);
        check("to_resp", {31'h0, resp_valid}, 32'h1);
        @(negedge clk);
        check("to_ready", {31'h0, req_ready}, 32'h1);
        check("to_resp_done", {31'h0, resp_valid}, 32'h0);

        // Back-to-back with req_valid held high and a 5-cycle ack wait.
        push(32'hCAFE_F00D, 1'b0, 1'b0);
        push(32'h1234_5678, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        addr = 32'h5004;
        wdata = 32'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_req", {31'h0, mem_req}, 32'h1);
            check("hold_addr", mem_addr, 32'h5004);
            check("hold_be", {28'h0, mem_be}, 32'hF);
            check("hold_ready", {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        check("b2b_resp_noreq", {31'h0, mem_req}, 32'h0);
        check("b2b_resp_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
        check("b2b_idle_noreq", {31'h0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("b2b_second_req", {31'h0, mem_req}, 32'h1);
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        wait_idle("b2b");

        // Reset in the middle of a bus access.
        send(1'b1, 2'b10, 1'b0, 32'h6000, 32'h7777_8888);
        @(negedge clk);
        check("rst_mid_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'h0, mem_req}, 32'h0);
        check("rst_mid_noresp", {31'h0, resp_valid}, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_ready", {31'h0, req_ready}, 32'h1);
        access_ack1("post_rst", 1'b0, 2'b10, 1'b0, 32'h8000, 32'h0, 32'h0BAD_F00D,
                    4'b1111, 32'h0, 32'h0BAD_F00D);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
